// File: rtl/mux_scan_serializer_pkg.sv
// Shared types for the parallel-to-serial scan serializer.
package mux_scan_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/mux_scan_serializer_sel_counter.sv
// Modulo-INS select counter: counts 0..INS-1 on en, wraps to 0, clr forces 0.
module scan_sel_counter #(
   parameter int INS   = 16,
   parameter int SEL_W = $clog2(INS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [SEL_W-1:0] q,
   output logic             last
);

   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(INS - 1);

   logic [SEL_W-1:0] q_q;
   logic [SEL_W-1:0] q_d;

   assign q    = q_q;
   assign last = (q_q == SEL_MAX);

   // Explicit wrap at INS-1 keeps the count in range for non-power-of-two INS.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         if (last) begin
            q_d = '0;
         end else begin
            q_d = q_q + SEL_W'(1);
         end
      end else begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/mux_scan_serializer.sv
// Captures a parallel word and emits it one bit per transfer on a valid/ready serial port.
module mux_scan_serializer
   import mux_scan_serializer_pkg::*;
#(
   parameter int INS       = 16,
   parameter int LSB_FIRST = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INS-1:0]         din,
   input  logic                   load_valid,
   output logic                   load_ready,
   output logic [$clog2(INS)-1:0] sel,
   output logic                   bit_out,
   output logic                   bit_valid,
   input  logic                   bit_ready,
   output logic                   done_tick
);

   localparam int SEL_W = $clog2(INS);

   state_e           state_q;
   state_e           state_d;
   logic [INS-1:0]   shadow_q;
   logic [INS-1:0]   shadow_d;
   logic [SEL_W-1:0] sel_s;
   logic             last_s;
   logic             xfer_s;
   logic             load_fire_s;
   logic             bit_sel_s;

   assign bit_valid   = (state_q == ST_SHIFT);
   assign xfer_s      = bit_valid && bit_ready;
   assign done_tick   = xfer_s && last_s;
   // The last-bit handshake reopens the load port so a waiting word follows with no bubble.
   assign load_ready  = (state_q == ST_IDLE) || (last_s && bit_ready);
   assign load_fire_s = load_valid && load_ready;
   assign sel         = sel_s;

   scan_sel_counter #(
      .INS   (INS),
      .SEL_W (SEL_W)
   ) u_sel_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (load_fire_s),
      .en    (xfer_s),
      .q     (sel_s),
      .last  (last_s)
   );

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      case (state_q)
         ST_IDLE: begin
            if (load_fire_s) begin
               shadow_d = din;
               state_d  = ST_SHIFT;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (done_tick) begin
               if (load_valid) begin
                  shadow_d = din;
                  state_d  = ST_SHIFT;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
      end
   end

   always_comb begin
      bit_sel_s = 1'b0;
      for (int k = 0; k < INS; k++) begin
         if (sel_s == SEL_W'(k)) begin
            if (LSB_FIRST != 0) begin
               bit_sel_s = shadow_q[k];
            end else begin
               bit_sel_s = shadow_q[INS-1-k];
            end
         end
      end
   end

   assign bit_out = bit_valid ? bit_sel_s : 1'b0;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: INS=8 LSB/MSB-first pair sharing stimulus, plus an INS=5 instance.
module tb_mux_scan_serializer;

   logic       clk = 1'b0;
   logic       reset;

   logic [7:0] din_ab;
   logic       lv_ab;
   logic       br_ab;
   logic       load_ready_a, bit_out_a, bit_valid_a, done_a;
   logic [2:0] sel_a;
   logic       load_ready_b, bit_out_b, bit_valid_b, done_b;
   logic [2:0] sel_b;

   logic [4:0] din_c;
   logic       lv_c;
   logic       br_c;
   logic       load_ready_c, bit_out_c, bit_valid_c, done_c;
   logic [2:0] sel_c;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] din;
      logic [7:0] lsb_seq;   // bit i = i-th emitted bit, LSB-first instance
      logic [7:0] msb_seq;   // bit i = i-th emitted bit, MSB-first instance
   } vec_t;

   vec_t vec [5];

   always #5 clk = ~clk;

   mux_scan_serializer #(.INS(8), .LSB_FIRST(1)) dut_a (
      .clk(clk), .reset(reset), .din(din_ab), .load_valid(lv_ab), .load_ready(load_ready_a),
      .sel(sel_a), .bit_out(bit_out_a), .bit_valid(bit_valid_a), .bit_ready(br_ab),
      .done_tick(done_a)
   );

   mux_scan_serializer #(.INS(8), .LSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .din(din_ab), .load_valid(lv_ab), .load_ready(load_ready_b),
      .sel(sel_b), .bit_out(bit_out_b), .bit_valid(bit_valid_b), .bit_ready(br_ab),
      .done_tick(done_b)
   );

   mux_scan_serializer #(.INS(5), .LSB_FIRST(1)) dut_c (
      .clk(clk), .reset(reset), .din(din_c), .load_valid(lv_c), .load_ready(load_ready_c),
      .sel(sel_c), .bit_out(bit_out_c), .bit_valid(bit_valid_c), .bit_ready(br_c),
      .done_tick(done_c)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Loads vec[v] into both 8-bit instances and follows it under continuous ready.
   task automatic run_word(input int v);
      din_ab = vec[v].din;
      lv_ab  = 1'b1;
      br_ab  = 1'b1;
      #1;
      chk("load_ready_idle_a", load_ready_a, 1);
      chk("load_ready_idle_b", load_ready_b, 1);
      @(posedge clk); #1;
      lv_ab  = 1'b0;
      din_ab = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("valid_a", bit_valid_a, 1);
         chk("sel_a", sel_a, i);
         chk("sel_b", sel_b, i);
         chk("bit_lsb_first", bit_out_a, vec[v].lsb_seq[i]);
         chk("bit_msb_first", bit_out_b, vec[v].msb_seq[i]);
         chk("done_a", done_a, (i == 7) ? 1 : 0);
         chk("done_b", done_b, (i == 7) ? 1 : 0);
         @(posedge clk); #1;
      end
      chk("idle_valid_a", bit_valid_a, 0);
      chk("idle_valid_b", bit_valid_b, 0);
      chk("idle_sel_a", sel_a, 0);
   endtask

   initial begin : main
      logic [10:0] bp_ready;
      logic [2:0]  bp_sel [11];
      logic [10:0] bp_bits;
      logic [9:0]  c_bits;

      vec[0] = '{din: 8'hA5, lsb_seq: 8'hA5, msb_seq: 8'hA5};
      vec[1] = '{din: 8'h1E, lsb_seq: 8'h1E, msb_seq: 8'h78};
      vec[2] = '{din: 8'h01, lsb_seq: 8'h01, msb_seq: 8'h80};
      vec[3] = '{din: 8'h6B, lsb_seq: 8'h6B, msb_seq: 8'hD6};
      vec[4] = '{din: 8'hC3, lsb_seq: 8'hC3, msb_seq: 8'hC3};

      reset  = 1'b1;
      din_ab = 8'h00; lv_ab = 1'b0; br_ab = 1'b0;
      din_c  = 5'b00000; lv_c = 1'b0; br_c = 1'b0;
      #12;
      chk("rst_valid", bit_valid_a, 0);
      chk("rst_sel", sel_a, 0);
      chk("rst_bit", bit_out_a, 0);
      chk("rst_done", done_a, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_load_ready", load_ready_a, 1);
      chk("rst_valid_c", bit_valid_c, 0);

      // Continuous-ready words on both bit orders.
      for (int v = 0; v < 5; v++) begin
         run_word(v);
      end

      // Backpressure at bit 2 with a stray load attempt of 8'hFF mid-word (word 8'h6B).
      bp_ready = 11'b111_1110_0011;  // bit c = ready in cycle c
      bp_sel   = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      bp_bits  = 11'b011_0100_0011;  // bit c = expected bit_out in cycle c
      din_ab = 8'h6B; lv_ab = 1'b1; br_ab = 1'b1;
      @(posedge clk); #1;
      lv_ab = 1'b0;
      for (int c = 0; c < 11; c++) begin
         br_ab  = bp_ready[c];
         lv_ab  = (c >= 1 && c <= 9) ? 1'b1 : 1'b0;
         din_ab = (c >= 1 && c <= 9) ? 8'hFF : 8'h00;
         #1;
         chk("bp_sel", sel_a, bp_sel[c]);
         chk("bp_bit", bit_out_a, bp_bits[c]);
         chk("bp_done", done_a, (c == 10) ? 1 : 0);
         chk("bp_load_ready", load_ready_a, (c == 10) ? 1 : 0);
         @(posedge clk); #1;
      end
      lv_ab = 1'b0; br_ab = 1'b1;
      chk("bp_idle", bit_valid_a, 0);

      // INS=5: two words back-to-back with load_valid held high.
      c_bits = 10'b01001_10110;  // bit c = expected bit in cycle c
      din_c = 5'b10110; lv_c = 1'b1; br_c = 1'b1;
      @(posedge clk); #1;
      din_c = 5'b01001;
      for (int c = 0; c < 10; c++) begin
         if (c == 9) lv_c = 1'b0;
         #1;
         chk("c_valid", bit_valid_c, 1);
         chk("c_sel", sel_c, c % 5);
         chk("c_bit", bit_out_c, c_bits[c]);
         chk("c_done", done_c, (c % 5 == 4) ? 1 : 0);
         chk("c_load_ready", load_ready_c, (c % 5 == 4) ? 1 : 0);
         @(posedge clk); #1;
      end
      chk("c_idle_valid", bit_valid_c, 0);
      chk("c_idle_sel", sel_c, 0);

      // Reset at sel=3 mid-word aborts, then a fresh word serializes from bit 0.
      din_ab = 8'hA5; lv_ab = 1'b1; br_ab = 1'b1;
      @(posedge clk); #1;
      lv_ab = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_sel", sel_a, 3);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", bit_valid_a, 0);
      chk("mid_rst_sel", sel_a, 0);
      chk("mid_rst_done", done_a, 0);
      chk("mid_rst_bit", bit_out_a, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_valid", bit_valid_a, 0);
      run_word(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
